// File: rtl/if_pkg.sv
// Shared constants and types for the instruction fetch queue.
package if_pkg;

  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
  localparam int unsigned PC_INC      = 4;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } if_state_e;

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Memory request/response, redirect and decode-side handshake bundle.
interface instr_fetch_queue_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               mem_req_valid;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic               mem_req_ready;
  logic               mem_rsp_valid;
  logic [INSTR_W-1:0] mem_rsp_data;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc_plus4;

  modport master (
    output mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc_plus4,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc_plus4,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/if_sync_fifo.sv
// Synchronous FIFO with flush; any DEPTH >= 1, read data forced to 0 while empty.
module if_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PTR_W-1:0]            rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        empty, full, do_push, do_pop;

  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = inc(wr_q);
      if (do_pop)  rd_d = inc(rd_q);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: reads are masked until something is written.
  always_ff @(posedge clock) begin
    if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = empty ? '0 : mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: credit-checked sequential fetch, in-order queue, redirect flush.
// Optional IF_PERF_CNT_EN adds perf_stall_cycles / perf_flushes counters.
module instr_fetch_queue import if_pkg::*; #(
  parameter int                ADDR_W    = 32,
  parameter int                INSTR_W   = 32,
  parameter int                DEPTH     = 4,
  parameter int                MAX_OUTST = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(IF_RESET_PC)
) (
  input  logic                 clock,
  input  logic                 reset,
  instr_fetch_queue_if.master  bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]          perf_stall_cycles,
  output logic [31:0]          perf_flushes
`endif
);

  localparam int QCNT_W = cnt_w(DEPTH);
  localparam int OCNT_W = cnt_w(MAX_OUTST);
  localparam int TCNT_W = cnt_w(MAX_OUTST);
  localparam int SUM_W  = QCNT_W + 1;
  localparam int QW     = INSTR_W + ADDR_W;

  if_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [OCNT_W-1:0]   outst_q, outst_d, drop_q, drop_d;

  logic [QCNT_W-1:0]   q_count;
  logic [QW-1:0]       q_rdata;
  logic [TCNT_W-1:0]   tag_count;
  logic [ADDR_W-1:0]   tag_pc;

  logic redirect, fire, rsp_take, rsp_acc, pop, out_valid, req_valid;

  assign redirect = bus.redirect_valid;

  // Credit check: every issued request is guaranteed a queue slot.
  assign req_valid = reset && (state_q == FETCH) && !redirect
                  && (outst_q < OCNT_W'(MAX_OUTST))
                  && ((SUM_W'(q_count) + SUM_W'(outst_q)) < SUM_W'(DEPTH));

  assign fire      = req_valid && bus.mem_req_ready;
  assign rsp_take  = bus.mem_rsp_valid && (outst_q != '0);
  assign rsp_acc   = rsp_take && (drop_q == '0) && !redirect && (tag_count != '0);
  assign out_valid = reset && (q_count != '0);
  assign pop       = out_valid && bus.out_ready;

  always_comb begin
    pc_d    = pc_q;
    outst_d = outst_q + OCNT_W'(fire) - OCNT_W'(rsp_take);
    drop_d  = drop_q;
    state_d = state_q;
    if (fire) pc_d = pc_q + ADDR_W'(PC_INC);
    if (redirect) begin
      pc_d    = bus.redirect_pc;
      drop_d  = outst_q - OCNT_W'(rsp_take);
      state_d = (drop_d != '0) ? FLUSH : FETCH;
    end else begin
      if (rsp_take && (drop_q != '0)) drop_d = drop_q - OCNT_W'(1);
      if ((state_q == FLUSH) && (drop_d == '0)) state_d = FETCH;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  // PCs of live requests, in issue order; entries always equal outst - drop.
  if_sync_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUTST)) u_tag_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush_i (redirect),
    .push_i  (fire),
    .wdata_i (pc_q),
    .pop_i   (rsp_acc),
    .rdata_o (tag_pc),
    .count_o (tag_count)
  );

  if_sync_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_instr_q (
    .clock   (clock),
    .reset   (reset),
    .flush_i (redirect),
    .push_i  (rsp_acc),
    .wdata_i ({bus.mem_rsp_data, tag_pc + ADDR_W'(PC_INC)}),
    .pop_i   (pop),
    .rdata_o (q_rdata),
    .count_o (q_count)
  );

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = pc_q;
  assign bus.out_valid     = out_valid;
  assign bus.out_instr     = q_rdata[ADDR_W +: INSTR_W];
  assign bus.out_pc_plus4  = q_rdata[ADDR_W-1:0];

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!out_valid && (state_q == FETCH)) stall_q <= stall_q + 32'd1;
      if (redirect)                         flush_q <= flush_q + 32'd1;
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_flushes      = flush_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a fixed-latency memory model (data = addr + 0x100).
module tb_instr_fetch_queue;

  logic clock, reset;
  instr_fetch_queue_if #(.ADDR_W(32), .INSTR_W(32)) bus ();
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flushes;
`endif

  instr_fetch_queue #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4), .MAX_OUTST(4), .RESET_PC(32'h0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes)
`endif
  );

  int checks = 0;
  int errors = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory model: requests seen mid-cycle, answered lat cycles later.
  typedef struct packed { logic [31:0] addr; int due; } mreq_t;
  mreq_t       mq[$];
  int          cyc = 0;
  int          lat = 1;
  logic        mem_en = 1'b1;
  logic        man_rsp_valid = 1'b0;
  logic [31:0] man_rsp_data = '0;

  initial begin
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    forever begin
      @(negedge clock);
      #2;
      cyc++;
      if (mem_en) begin
        if (mq.size() > 0 && mq[0].due == cyc) begin
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rsp_data  = mq[0].addr + 32'h100;
          void'(mq.pop_front());
        end else begin
          bus.mem_rsp_valid = 1'b0;
        end
        if (bus.mem_req_valid && bus.mem_req_ready)
          mq.push_back('{addr: bus.mem_req_addr, due: cyc + lat});
      end else begin
        mq.delete();
        bus.mem_rsp_valid = man_rsp_valid;
        bus.mem_rsp_data  = man_rsp_data;
      end
    end
  end

  task automatic do_reset(input int l, input logic rdy, input logic ordy);
    @(negedge clock);
    reset = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    repeat (5) @(negedge clock);
    lat = l;
    reset = 1'b1;
    bus.mem_req_ready = rdy;
    bus.out_ready     = ordy;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (2) @(negedge clock);
    #3;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valids: out_valid=%b req_valid=%b, expected 0 0", bus.out_valid, bus.mem_req_valid);
    end
    checks++;
    if (bus.out_instr !== 32'h0 || bus.out_pc_plus4 !== 32'h0) begin
      errors++; $display("FAIL reset_data: instr=%h pc4=%h, expected 0 0", bus.out_instr, bus.out_pc_plus4);
    end
    @(negedge clock);
    reset = 1'b1;
    #3;
    checks++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h0) begin
      errors++; $display("FAIL reset_first_req: valid=%b addr=%h, expected 1 00000000", bus.mem_req_valid, bus.mem_req_addr);
    end
  endtask

  task automatic test_stream();
    do_reset(1, 1'b1, 1'b1);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clock);
      #3;
      checks++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'(4 * c)) begin
        errors++; $display("FAIL stream_req c=%0d: valid=%b addr=%h, expected 1 %h", c, bus.mem_req_valid, bus.mem_req_addr, 32'(4 * c));
      end
      checks++;
      if (c < 2) begin
        if (bus.out_valid !== 1'b0) begin
          errors++; $display("FAIL stream_lat c=%0d: out_valid=%b, expected 0", c, bus.out_valid);
        end
      end else if (bus.out_valid !== 1'b1 || bus.out_pc_plus4 !== 32'(4 * (c - 1)) || bus.out_instr !== 32'(4 * (c - 2) + 256)) begin
        errors++; $display("FAIL stream_out c=%0d: v=%b pc4=%h instr=%h, expected 1 %h %h", c, bus.out_valid, bus.out_pc_plus4, bus.out_instr, 32'(4 * (c - 1)), 32'(4 * (c - 2) + 256));
      end
    end
  endtask

  task automatic test_backpressure();
    int fires = 0;
    int got = 0;
    logic [31:0] exp_pc4 = 32'h4;
    do_reset(1, 1'b1, 1'b0);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clock);
      #3;
      if (bus.mem_req_valid && bus.mem_req_ready) fires++;
    end
    checks++;
    if (fires != 4) begin
      errors++; $display("FAIL bp_fires: issued %0d, expected 4", fires);
    end
    checks++;
    if (bus.mem_req_valid !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_pc_plus4 !== 32'h4) begin
      errors++; $display("FAIL bp_full: req_valid=%b out_valid=%b pc4=%h, expected 0 1 00000004", bus.mem_req_valid, bus.out_valid, bus.out_pc_plus4);
    end
    for (int c = 0; c < 30 && got < 6; c++) begin
      @(negedge clock);
      bus.out_ready = 1'b1;
      #3;
      if (bus.out_valid) begin
        checks++;
        if (bus.out_pc_plus4 !== exp_pc4 || bus.out_instr !== exp_pc4 + 32'hFC) begin
          errors++; $display("FAIL bp_drain item %0d: pc4=%h instr=%h, expected %h %h", got, bus.out_pc_plus4, bus.out_instr, exp_pc4, exp_pc4 + 32'hFC);
        end
        exp_pc4 += 32'h4;
        got++;
      end
    end
    checks++;
    if (got != 6) begin
      errors++; $display("FAIL bp_drain_count: got %0d items, expected 6", got);
    end
  endtask

  task automatic test_redirect_flush();
    do_reset(3, 1'b1, 1'b1);
    for (int c = 0; c < 11; c++) begin
      if (c > 0) @(negedge clock);
      bus.redirect_valid = (c == 2);
      bus.redirect_pc    = 32'h40;
      #3;
      if (c >= 2 && c <= 4) begin
        checks++;
        if (bus.mem_req_valid !== 1'b0) begin
          errors++; $display("FAIL rf_noissue c=%0d: req_valid=%b, expected 0", c, bus.mem_req_valid);
        end
      end
      if (c == 5) begin
        checks++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h40) begin
          errors++; $display("FAIL rf_resume: valid=%b addr=%h, expected 1 00000040", bus.mem_req_valid, bus.mem_req_addr);
        end
      end
      if (c >= 2 && c <= 8) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin
          errors++; $display("FAIL rf_stale c=%0d: out_valid=%b, expected 0", c, bus.out_valid);
        end
      end
      if (c == 9 || c == 10) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc_plus4 !== 32'(32'h44 + 4 * (c - 9)) || bus.out_instr !== 32'(32'h140 + 4 * (c - 9))) begin
          errors++; $display("FAIL rf_first c=%0d: v=%b pc4=%h instr=%h, expected 1 %h %h", c, bus.out_valid, bus.out_pc_plus4, bus.out_instr, 32'(32'h44 + 4 * (c - 9)), 32'(32'h140 + 4 * (c - 9)));
        end
      end
    end
  endtask

  task automatic test_redirect_collide();
    do_reset(3, 1'b1, 1'b1);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clock);
      bus.redirect_valid = (c == 3) || (c == 4);
      bus.redirect_pc    = (c == 3) ? 32'h80 : 32'hC0;
      #3;
      if (c >= 3 && c <= 5) begin
        checks++;
        if (bus.mem_req_valid !== 1'b0) begin
          errors++; $display("FAIL rc_noissue c=%0d: req_valid=%b, expected 0", c, bus.mem_req_valid);
        end
      end
      if (c == 6) begin
        checks++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'hC0) begin
          errors++; $display("FAIL rc_resume: valid=%b addr=%h, expected 1 000000c0", bus.mem_req_valid, bus.mem_req_addr);
        end
      end
      if (c >= 3 && c <= 9) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin
          errors++; $display("FAIL rc_stale c=%0d: out_valid=%b, expected 0", c, bus.out_valid);
        end
      end
      if (c == 10 || c == 11) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc_plus4 !== 32'(32'hC4 + 4 * (c - 10)) || bus.out_instr !== 32'(32'h1C0 + 4 * (c - 10))) begin
          errors++; $display("FAIL rc_first c=%0d: v=%b pc4=%h instr=%h, expected 1 %h %h", c, bus.out_valid, bus.out_pc_plus4, bus.out_instr, 32'(32'hC4 + 4 * (c - 10)), 32'(32'h1C0 + 4 * (c - 10)));
        end
      end
    end
  endtask

  task automatic test_midstream_reset();
    do_reset(1, 1'b1, 1'b0);
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clock);
      #3;
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.mem_req_valid !== 1'b0 || bus.out_pc_plus4 !== 32'h4) begin
      errors++; $display("FAIL mr_full: out_valid=%b req_valid=%b pc4=%h, expected 1 0 00000004", bus.out_valid, bus.mem_req_valid, bus.out_pc_plus4);
    end
    @(negedge clock);
    mem_en = 1'b0;
    reset = 1'b0;
    bus.mem_req_ready = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    man_rsp_valid = 1'b1;
    man_rsp_data  = 32'hDEAD_BEEF;
    #3;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h0 || bus.out_pc_plus4 !== 32'h0) begin
      errors++; $display("FAIL mr_cleared: out_valid=%b req_valid=%b addr=%h pc4=%h, expected 0 1 0 0", bus.out_valid, bus.mem_req_valid, bus.mem_req_addr, bus.out_pc_plus4);
    end
    @(negedge clock);
    man_rsp_valid = 1'b0;
    #3;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0) begin
      errors++; $display("FAIL mr_late_rsp: out_valid=%b instr=%h, expected 0 00000000", bus.out_valid, bus.out_instr);
    end
    mem_en = 1'b1;
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf();
    int exp_stall = 0;
    do_reset(1, 1'b0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clock);
      bus.redirect_valid = (c == 1) || (c == 3) || (c == 5);
      bus.redirect_pc    = 32'h200;
      #3;
      if (c == 7) begin
        checks++;
        if (perf_flushes !== 32'd3) begin
          errors++; $display("FAIL perf_flushes: got %0d, expected 3", perf_flushes);
        end
        checks++;
        if (perf_stall_cycles !== 32'(exp_stall)) begin
          errors++; $display("FAIL perf_stall: got %0d, expected %0d", perf_stall_cycles, exp_stall);
        end
      end
      if (bus.out_valid === 1'b0) exp_stall++;
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_collide();
    test_midstream_reset();
`ifdef IF_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
